alu_latency_monitor: RTL and testbench

Synthesizable, parametrised per-channel latency and protocol monitor for the banked ALU. It watches each channel's command-issue and response-return strobes, measures issue-to-response latency, and scores each transaction against a configurable [MIN_LAT, MAX_LAT] window. It flags timeouts and protocol violations and keeps saturating pass/fail totals. It sits alongside the ALU and replaces bench-only scoreboard checking with reusable on-chip logic.

---
 rtl/alu_latency_monitor.sv | 144 ++++++++++++++
 tb/tb_alu_latency_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_latency_monitor.sv
// Per-channel issue-to-response latency monitor for the banked ALU.
// Scores each transaction against [MIN_LAT, MAX_LAT] and keeps saturating pass/fail totals.
//
// state  | meaning
// S_IDLE | no transaction outstanding; a response here is an orphan
// S_WAIT | command issued, counting cycles until response or timeout
module alu_latency_monitor #(
    parameter int NUM_CH  = 4,
    parameter int MIN_LAT = 3,
    parameter int MAX_LAT = 5,
    parameter int CNT_W   = 16,
    parameter int LAT_W   = $clog2(MAX_LAT + 1) + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       cmd_valid,
    input  logic [NUM_CH-1:0]       resp_valid,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       pass_pulse,
    output logic [NUM_CH-1:0]       fail_pulse,
    output logic [NUM_CH-1:0]       timeout_pulse,
    output logic [NUM_CH-1:0]       proto_err_pulse,
    output logic [NUM_CH*LAT_W-1:0] last_latency,
    output logic [CNT_W-1:0]        pass_count,
    output logic [CNT_W-1:0]        fail_count
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam int SUM_W = CNT_W + $clog2(NUM_CH + 1);
    localparam logic [LAT_W-1:0] MIN_L   = LAT_W'(MIN_LAT);
    localparam logic [LAT_W-1:0] MAX_L   = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] TOUT_L  = LAT_W'(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] ONE_L   = LAT_W'(1);
    localparam logic [SUM_W-1:0] SAT_LIM = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    state_t           r_state [NUM_CH];
    logic [LAT_W-1:0] r_cnt   [NUM_CH];

    logic [NUM_CH-1:0] w_pass_ev;
    logic [NUM_CH-1:0] w_fail_ev;
    logic [SUM_W-1:0]  w_pass_sum;
    logic [SUM_W-1:0]  w_fail_sum;
    logic [CNT_W-1:0]  w_pass_next;
    logic [CNT_W-1:0]  w_fail_next;

    function automatic logic [SUM_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [SUM_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_CH; i++) p = p + SUM_W'(v[i]);
        return p;
    endfunction

    // Scoring events are decoded once so pulses and totals cannot disagree.
    always_comb begin
        w_pass_ev = '0;
        w_fail_ev = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_state[i] == S_WAIT) begin
                if (resp_valid[i]) begin
                    if (r_cnt[i] >= MIN_L && r_cnt[i] <= MAX_L) w_pass_ev[i] = 1'b1;
                    else if (r_cnt[i] < MIN_L)                  w_fail_ev[i] = 1'b1;
                end else if (r_cnt[i] == MAX_L) begin
                    w_fail_ev[i] = 1'b1;
                end
            end
        end
        w_pass_sum  = {{(SUM_W-CNT_W){1'b0}}, pass_count} + popcount(w_pass_ev);
        w_fail_sum  = {{(SUM_W-CNT_W){1'b0}}, fail_count} + popcount(w_fail_ev);
        w_pass_next = (w_pass_sum > SAT_LIM) ? {CNT_W{1'b1}} : w_pass_sum[CNT_W-1:0];
        w_fail_next = (w_fail_sum > SAT_LIM) ? {CNT_W{1'b1}} : w_fail_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            pass_pulse      <= '0;
            fail_pulse      <= '0;
            timeout_pulse   <= '0;
            proto_err_pulse <= '0;
            last_latency    <= '0;
            pass_count      <= '0;
            fail_count      <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            pass_pulse      <= '0;
            fail_pulse      <= '0;
            timeout_pulse   <= '0;
            proto_err_pulse <= '0;
            last_latency    <= '0;
            pass_count      <= '0;
            fail_count      <= '0;
        end else begin
            pass_pulse      <= w_pass_ev;
            fail_pulse      <= w_fail_ev;
            timeout_pulse   <= '0;
            proto_err_pulse <= '0;
            pass_count      <= w_pass_next;
            fail_count      <= w_fail_next;
            for (int i = 0; i < NUM_CH; i++) begin
                case (r_state[i])
                    S_IDLE: begin
                        if (resp_valid[i]) proto_err_pulse[i] <= 1'b1;
                        if (cmd_valid[i]) begin
                            r_state[i] <= S_WAIT;
                            r_cnt[i]   <= ONE_L;
                        end
                    end
                    S_WAIT: begin
                        if (resp_valid[i]) begin
                            last_latency[i*LAT_W +: LAT_W] <= r_cnt[i];
                            if (cmd_valid[i]) r_cnt[i]   <= ONE_L;
                            else              r_state[i] <= S_IDLE;
                        end else begin
                            // Stray command: keep timing the outstanding transaction.
                            if (cmd_valid[i]) proto_err_pulse[i] <= 1'b1;
                            if (r_cnt[i] == MAX_L) begin
                                timeout_pulse[i]               <= 1'b1;
                                last_latency[i*LAT_W +: LAT_W] <= TOUT_L;
                                r_state[i]                     <= S_IDLE;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + ONE_L;
                            end
                        end
                    end
                    default: r_state[i] <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) busy[i] = (r_state[i] == S_WAIT);
    end

endmodule

// File: tb/tb_alu_latency_monitor.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares each cycle.
// A second instance with 2-bit totals exercises counter saturation on the same stimulus.
module tb_alu_latency_monitor;

    localparam int NCH  = 4;
    localparam int MINL = 3;
    localparam int MAXL = 5;
    localparam int LW   = $clog2(MAXL + 1) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [NCH-1:0]   cmd_valid  = '0;
    logic [NCH-1:0]   resp_valid = '0;

    logic [NCH-1:0]    busy, pass_pulse, fail_pulse, timeout_pulse, proto_err_pulse;
    logic [NCH*LW-1:0] last_latency;
    logic [15:0]       pass_count, fail_count;

    logic [NCH-1:0]    s_busy, s_pass, s_fail, s_to, s_proto;
    logic [NCH*LW-1:0] s_last;
    logic [1:0]        s_pass_count, s_fail_count;

    alu_latency_monitor #(.NUM_CH(NCH), .MIN_LAT(MINL), .MAX_LAT(MAXL), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .clear(clear),
        .cmd_valid(cmd_valid), .resp_valid(resp_valid),
        .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .timeout_pulse(timeout_pulse), .proto_err_pulse(proto_err_pulse),
        .last_latency(last_latency), .pass_count(pass_count), .fail_count(fail_count)
    );

    alu_latency_monitor #(.NUM_CH(NCH), .MIN_LAT(MINL), .MAX_LAT(MAXL), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .clear(clear),
        .cmd_valid(cmd_valid), .resp_valid(resp_valid),
        .busy(s_busy), .pass_pulse(s_pass), .fail_pulse(s_fail),
        .timeout_pulse(s_to), .proto_err_pulse(s_proto),
        .last_latency(s_last), .pass_count(s_pass_count), .fail_count(s_fail_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NCH-1:0]    busy, pass, fail, to, proto;
        logic [NCH*LW-1:0] last;
        logic [15:0]       pc, fc;
        logic [1:0]        spc, sfc;
    } exp_t;

    exp_t scb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: each channel remembers the edge number of its outstanding issue.
    int   edge_n = 0;
    bit   outst  [NCH];
    int   iss    [NCH];
    int   lastl  [NCH];
    int   tot_p  = 0;
    int   tot_f  = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic exp_t model_step(input logic [NCH-1:0] c, input logic [NCH-1:0] r,
                                        input logic rst_v, input logic clr_v);
        exp_t e;
        int   lat;
        e.pass = '0; e.fail = '0; e.to = '0; e.proto = '0; e.busy = '0; e.last = '0;
        edge_n++;
        if (!rst_v || clr_v) begin
            for (int i = 0; i < NCH; i++) begin outst[i] = 0; lastl[i] = 0; end
            tot_p = 0; tot_f = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (outst[i]) begin
                    lat = edge_n - iss[i];
                    if (r[i]) begin
                        lastl[i] = lat;
                        if (lat >= MINL) e.pass[i] = 1'b1; else e.fail[i] = 1'b1;
                        if (c[i]) iss[i] = edge_n; else outst[i] = 0;
                    end else begin
                        if (c[i]) e.proto[i] = 1'b1;
                        if (lat == MAXL) begin
                            e.to[i] = 1'b1; e.fail[i] = 1'b1;
                            lastl[i] = MAXL + 1; outst[i] = 0;
                        end
                    end
                end else begin
                    if (r[i]) e.proto[i] = 1'b1;
                    if (c[i]) begin outst[i] = 1; iss[i] = edge_n; end
                end
                tot_p += int'(e.pass[i]);
                tot_f += int'(e.fail[i]);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            e.busy[i] = outst[i];
            e.last[i*LW +: LW] = LW'(lastl[i]);
        end
        e.pc  = 16'(imin(tot_p, 65535));
        e.fc  = 16'(imin(tot_f, 65535));
        e.spc = 2'(imin(tot_p, 3));
        e.sfc = 2'(imin(tot_f, 3));
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, expv);
    endtask

    task automatic drive(input logic [NCH-1:0] c, input logic [NCH-1:0] r,
                         input logic rst_v = 1'b1, input logic clr_v = 1'b0);
        @(negedge clock);
        cmd_valid  = c;
        resp_valid = r;
        reset      = rst_v;
        clear      = clr_v;
        scb_q.push_back(model_step(c, r, rst_v, clr_v));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (scb_q.size() > 0) begin
                e = scb_q.pop_front();
                chk("busy",        32'(busy),            32'(e.busy));
                chk("pass_pulse",  32'(pass_pulse),      32'(e.pass));
                chk("fail_pulse",  32'(fail_pulse),      32'(e.fail));
                chk("timeout",     32'(timeout_pulse),   32'(e.to));
                chk("proto_err",   32'(proto_err_pulse), 32'(e.proto));
                chk("last_lat",    32'(last_latency),    32'(e.last));
                chk("pass_count",  32'(pass_count),      32'(e.pc));
                chk("fail_count",  32'(fail_count),      32'(e.fc));
                chk("sat_pass",    32'(s_pass_count),    32'(e.spc));
                chk("sat_fail",    32'(s_fail_count),    32'(e.sfc));
            end
        end
    end

    initial begin : driver
        logic [NCH-1:0] c, r;
        drive('0, '0, 1'b0);
        idle(1);
        // reset mid-operation, then orphan response on ch0
        drive(4'b0001, '0); idle(1);
        drive('0, '0, 1'b0);
        idle(1);
        drive('0, 4'b0001);
        // in-window on ch1
        drive(4'b0010, '0); idle(2); drive('0, 4'b0010); idle(1);
        // early then back-to-back on ch2, then latency 5
        drive(4'b0100, '0); idle(1); drive(4'b0100, 4'b0100); idle(4); drive('0, 4'b0100); idle(1);
        // timeout on ch3, then late orphan
        drive(4'b1000, '0); idle(6); drive('0, 4'b1000); idle(1);
        // all channels together
        drive(4'b1111, '0); idle(3); drive('0, 4'b1111); idle(1);
        // five passes on ch0 saturate the 2-bit totals, then clear
        for (int k = 0; k < 5; k++) begin drive(4'b0001, '0); idle(2); drive('0, 4'b0001); end
        idle(1);
        drive('0, '0, 1'b1, 1'b1);
        idle(1);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NCH; i++) begin
                c[i] = ($urandom_range(0, 3) == 0);
                r[i] = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 399) == 0)      drive(c, r, 1'b0);
            else if ($urandom_range(0, 299) == 0) drive(c, r, 1'b1, 1'b1);
            else                                  drive(c, r);
        end
        idle(2);
        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(scb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
